// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite responder with four 32-bit control registers, parallel register
// outputs and a one-cycle write strobe per register.
module axi4lite_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     REG0_OUT,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     REG1_OUT,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     REG2_OUT,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     REG3_OUT,
    output logic [3:0]                        WR_PULSE
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;
    localparam int AW = C_S_AXI_ADDR_WIDTH;

    // Bytewise merge: strobed bytes come from the new value, the rest are kept.
    function automatic logic [DW-1:0] merge_bytes(
        input logic [DW-1:0] old_v,
        input logic [DW-1:0] new_v,
        input logic [SW-1:0] strb
    );
        logic [DW-1:0] res;
        res = old_v;
        for (int k = 0; k < SW; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_v[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_v[8*k +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] sel);
        logic [3:0] res;
        case (sel)
            2'd0:    res = 4'b0001;
            2'd1:    res = 4'b0010;
            2'd2:    res = 4'b0100;
            2'd3:    res = 4'b1000;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    logic            aw_held_q, aw_held_d;
    logic [AW-1:0]   awaddr_q,  awaddr_d;
    logic            w_held_q,  w_held_d;
    logic [DW-1:0]   wdata_q,   wdata_d;
    logic [SW-1:0]   wstrb_q,   wstrb_d;
    logic            bvalid_q,  bvalid_d;
    logic [3:0]      wr_pulse_q, wr_pulse_d;
    logic            rvalid_q,  rvalid_d;
    logic [DW-1:0]   rdata_q,   rdata_d;
    logic [DW-1:0]   regs_q [4];
    logic [DW-1:0]   regs_d [4];

    logic            awready_s, wready_s, arready_s;
    logic            aw_hs_s, w_hs_s, ar_hs_s, b_hs_s, r_hs_s;
    logic            commit_s;
    logic [1:0]      wr_sel_s, rd_sel_s;
    logic [DW-1:0]   wr_data_s;
    logic [SW-1:0]   wr_strb_s;
    logic            prot_unused_s;

    assign prot_unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Ready signals come only from registered state, never from VALID inputs.
    assign awready_s = !aw_held_q && !bvalid_q;
    assign wready_s  = !w_held_q  && !bvalid_q;
    assign arready_s = !rvalid_q;

    assign aw_hs_s = S_AXI_AWVALID && awready_s;
    assign w_hs_s  = S_AXI_WVALID  && wready_s;
    assign ar_hs_s = S_AXI_ARVALID && arready_s;
    assign b_hs_s  = bvalid_q && S_AXI_BREADY;
    assign r_hs_s  = rvalid_q && S_AXI_RREADY;

    // A write commits as soon as address and data are both available, held or live.
    assign commit_s  = (aw_held_q || aw_hs_s) && (w_held_q || w_hs_s);
    assign wr_sel_s  = aw_held_q ? awaddr_q[3:2] : S_AXI_AWADDR[3:2];
    assign wr_data_s = w_held_q  ? wdata_q : S_AXI_WDATA;
    assign wr_strb_s = w_held_q  ? wstrb_q : S_AXI_WSTRB;
    assign rd_sel_s  = S_AXI_ARADDR[3:2];

    // Write-channel next state: address/data capture, response and strobe.
    always_comb begin
        aw_held_d  = aw_held_q;
        awaddr_d   = awaddr_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        wr_pulse_d = 4'b0000;
        if (aw_hs_s) begin
            awaddr_d = S_AXI_AWADDR;
        end else begin
            awaddr_d = awaddr_q;
        end
        if (w_hs_s) begin
            wdata_d = S_AXI_WDATA;
            wstrb_d = S_AXI_WSTRB;
        end else begin
            wdata_d = wdata_q;
            wstrb_d = wstrb_q;
        end
        if (commit_s) begin
            aw_held_d  = 1'b0;
            w_held_d   = 1'b0;
            bvalid_d   = 1'b1;
            wr_pulse_d = onehot4(wr_sel_s);
        end else begin
            aw_held_d = aw_held_q || aw_hs_s;
            w_held_d  = w_held_q  || w_hs_s;
            if (b_hs_s) begin
                bvalid_d = 1'b0;
            end else begin
                bvalid_d = bvalid_q;
            end
        end
    end

    // Register file next state: only the committed register changes.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            if (commit_s && (wr_sel_s == 2'(n))) begin
                regs_d[n] = merge_bytes(regs_q[n], wr_data_s, wr_strb_s);
            end else begin
                regs_d[n] = regs_q[n];
            end
        end
    end

    // Read channel next state; RDATA samples the pre-commit register value.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (ar_hs_s) begin
            rvalid_d = 1'b1;
            rdata_d  = regs_q[rd_sel_s];
        end else if (r_hs_s) begin
            rvalid_d = 1'b0;
            rdata_d  = rdata_q;
        end else begin
            rvalid_d = rvalid_q;
            rdata_d  = rdata_q;
        end
    end

    // State registers; reset abandons any partially received write.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held_q  <= 1'b0;
            awaddr_q   <= {AW{1'b0}};
            w_held_q   <= 1'b0;
            wdata_q    <= {DW{1'b0}};
            wstrb_q    <= {SW{1'b0}};
            bvalid_q   <= 1'b0;
            wr_pulse_q <= 4'b0000;
            rvalid_q   <= 1'b0;
            rdata_q    <= {DW{1'b0}};
            for (int n = 0; n < 4; n++) begin
                regs_q[n] <= {DW{1'b0}};
            end
        end else begin
            aw_held_q  <= aw_held_d;
            awaddr_q   <= awaddr_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            wr_pulse_q <= wr_pulse_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            for (int n = 0; n < 4; n++) begin
                regs_q[n] <= regs_d[n];
            end
        end
    end

    assign S_AXI_AWREADY = awready_s;
    assign S_AXI_WREADY  = wready_s;
    assign S_AXI_ARREADY = arready_s;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign REG0_OUT      = regs_q[0];
    assign REG1_OUT      = regs_q[1];
    assign REG2_OUT      = regs_q[2];
    assign REG3_OUT      = regs_q[3];
    assign WR_PULSE      = wr_pulse_q;

endmodule
